// File: rtl/axi_csr_arb.sv
// Shares one CSR port between the AXI read and write front ends, one transaction at a time,
// round-robin on ties; write error captured at issue, read data/error RD_LATENCY cycles later.
module axi_csr_arb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk_axi,
  input  logic              arst_axi,
  input  logic              rd_req_valid_i,
  output logic              rd_req_ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_resp_valid_o,
  input  logic              rd_resp_ready_i,
  output logic [DATA_W-1:0] rd_resp_data_o,
  output logic              rd_resp_err_o,
  input  logic              wr_req_valid_i,
  output logic              wr_req_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_resp_valid_o,
  input  logic              wr_resp_ready_i,
  output logic              wr_resp_err_o,
  output logic              csr_valid_o,
  output logic              csr_rd_or_wr_o,
  output logic [ADDR_W-1:0] csr_addr_o,
  output logic [DATA_W-1:0] csr_data_o,
  input  logic              csr_ready_i,
  input  logic              csr_error_i,
  input  logic [DATA_W-1:0] csr_data_i
);

  typedef enum logic [2:0] {IDLE, ISSUE, RD_WAIT, RD_RESP, WR_RESP} state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY - 1);

  state_t            state_q;
  logic              rr_last_wr_q;
  logic              is_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rerr_q;
  logic              werr_q;
  logic [2:0]        lat_cnt_q;

  logic grant_rd_d;
  logic grant_wr_d;

  // On a tie the side that did not win last time is granted.
  assign grant_rd_d = (state_q == IDLE) && !arst_axi && rd_req_valid_i && (!wr_req_valid_i || rr_last_wr_q);
  assign grant_wr_d = (state_q == IDLE) && !arst_axi && wr_req_valid_i && (!rd_req_valid_i || !rr_last_wr_q);

  assign rd_req_ready_o  = grant_rd_d;
  assign wr_req_ready_o  = grant_wr_d;
  assign csr_valid_o     = (state_q == ISSUE);
  assign csr_rd_or_wr_o  = is_wr_q;
  assign csr_addr_o      = addr_q;
  assign csr_data_o      = wdata_q;
  assign rd_resp_valid_o = (state_q == RD_RESP);
  assign rd_resp_data_o  = rdata_q;
  assign rd_resp_err_o   = rerr_q;
  assign wr_resp_valid_o = (state_q == WR_RESP);
  assign wr_resp_err_o   = werr_q;

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      state_q      <= IDLE;
      rr_last_wr_q <= 1'b1;
      is_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rerr_q       <= 1'b0;
      werr_q       <= 1'b0;
      lat_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_rd_d || grant_wr_d) begin
            is_wr_q      <= grant_wr_d;
            addr_q       <= grant_wr_d ? wr_addr_i : rd_addr_i;
            wdata_q      <= grant_wr_d ? wr_data_i : '0;
            rr_last_wr_q <= grant_wr_d;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (csr_ready_i) begin
            if (is_wr_q) begin
              werr_q  <= csr_error_i;
              state_q <= WR_RESP;
            end else begin
              lat_cnt_q <= LAT_INIT;
              state_q   <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt_q == 3'd0) begin
            rdata_q <= csr_data_i;
            rerr_q  <= csr_error_i;
            state_q <= RD_RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 3'd1;
          end
        end
        RD_RESP: if (rd_resp_ready_i) state_q <= IDLE;
        WR_RESP: if (wr_resp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_csr_arb.sv
// Directed bench for axi_csr_arb: per-cycle vector table plus hand sequences for
// CSR stall, RD_LATENCY=3 sampling and reset during a read.
module tb_axi_csr_arb;

  logic        clk_axi = 1'b0;
  logic        arst_axi;
  logic        rd_req_valid_i, rd_resp_ready_i, wr_req_valid_i, wr_resp_ready_i;
  logic [15:0] rd_addr_i, wr_addr_i;
  logic [31:0] wr_data_i, csr_data_i;
  logic        csr_ready_i, csr_error_i;

  logic        rd_req_ready_o, rd_resp_valid_o, rd_resp_err_o;
  logic        wr_req_ready_o, wr_resp_valid_o, wr_resp_err_o;
  logic        csr_valid_o, csr_rd_or_wr_o;
  logic [15:0] csr_addr_o;
  logic [31:0] rd_resp_data_o, csr_data_o;

  logic        l_rd_req_ready, l_rd_resp_valid, l_rd_resp_err;
  logic        l_wr_req_ready, l_wr_resp_valid, l_wr_resp_err;
  logic        l_csr_valid, l_csr_rd_or_wr;
  logic [15:0] l_csr_addr;
  logic [31:0] l_rd_resp_data, l_csr_data;

  int checks = 0;
  int failures = 0;

  always #5 clk_axi = ~clk_axi;

  axi_csr_arb #(.ADDR_W(16), .DATA_W(32), .RD_LATENCY(1)) dut (
    .clk_axi(clk_axi), .arst_axi(arst_axi),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o), .rd_addr_i(rd_addr_i),
    .rd_resp_valid_o(rd_resp_valid_o), .rd_resp_ready_i(rd_resp_ready_i),
    .rd_resp_data_o(rd_resp_data_o), .rd_resp_err_o(rd_resp_err_o),
    .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_resp_valid_o(wr_resp_valid_o), .wr_resp_ready_i(wr_resp_ready_i),
    .wr_resp_err_o(wr_resp_err_o),
    .csr_valid_o(csr_valid_o), .csr_rd_or_wr_o(csr_rd_or_wr_o), .csr_addr_o(csr_addr_o),
    .csr_data_o(csr_data_o), .csr_ready_i(csr_ready_i), .csr_error_i(csr_error_i),
    .csr_data_i(csr_data_i)
  );

  axi_csr_arb #(.ADDR_W(16), .DATA_W(32), .RD_LATENCY(3)) dut_lat3 (
    .clk_axi(clk_axi), .arst_axi(arst_axi),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(l_rd_req_ready), .rd_addr_i(rd_addr_i),
    .rd_resp_valid_o(l_rd_resp_valid), .rd_resp_ready_i(rd_resp_ready_i),
    .rd_resp_data_o(l_rd_resp_data), .rd_resp_err_o(l_rd_resp_err),
    .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(l_wr_req_ready), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_resp_valid_o(l_wr_resp_valid), .wr_resp_ready_i(wr_resp_ready_i),
    .wr_resp_err_o(l_wr_resp_err),
    .csr_valid_o(l_csr_valid), .csr_rd_or_wr_o(l_csr_rd_or_wr), .csr_addr_o(l_csr_addr),
    .csr_data_o(l_csr_data), .csr_ready_i(csr_ready_i), .csr_error_i(csr_error_i),
    .csr_data_i(csr_data_i)
  );

  typedef struct {
    logic        rv, wv;
    logic [15:0] ra, wa;
    logic [31:0] wd;
    logic        rrr, wrr, crdy, cerr;
    logic [31:0] cdat;
    logic        e_rrdy, e_wrdy, e_cv, e_cw;
    logic [15:0] e_caddr;
    logic [31:0] e_cdo;
    logic        e_rvld;
    logic [31:0] e_rdat;
    logic        e_rerr, e_wvld, e_werr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rv, wv, input logic [15:0] ra, wa, input logic [31:0] wd,
                     input logic rrr, wrr, crdy, cerr, input logic [31:0] cdat,
                     input logic e_rrdy, e_wrdy, e_cv, e_cw, input logic [15:0] e_caddr,
                     input logic [31:0] e_cdo, input logic e_rvld, input logic [31:0] e_rdat,
                     input logic e_rerr, e_wvld, e_werr);
    vec_t v;
    v = '{rv, wv, ra, wa, wd, rrr, wrr, crdy, cerr, cdat,
          e_rrdy, e_wrdy, e_cv, e_cw, e_caddr, e_cdo, e_rvld, e_rdat, e_rerr, e_wvld, e_werr};
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    rd_req_valid_i = 0; wr_req_valid_i = 0; rd_addr_i = '0; wr_addr_i = '0; wr_data_i = '0;
    rd_resp_ready_i = 1; wr_resp_ready_i = 1; csr_ready_i = 1; csr_error_i = 0; csr_data_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_axi);
    idle_inputs();
    arst_axi = 1;
    @(negedge clk_axi);
    arst_axi = 0;
  endtask

  initial begin
    arst_axi = 1;
    idle_inputs();

    // Single read, then two writes (error clear / set).
    add(1,0,16'h1000,0,0, 1,1,1,0,0,          1,0,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,        1,1,1,0,0,          0,0,1,0,16'h1000,0, 0,0,0,0,0);
    add(0,0,0,0,0,        1,1,1,0,32'hCAFE_0001, 0,0,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,        1,1,1,0,0,          0,0,0,0,0,0, 1,32'hCAFE_0001,0,0,0);
    add(0,1,0,16'h100C,3, 1,1,1,0,0,          0,1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,        1,1,1,0,0,          0,0,1,1,16'h100C,3, 0,0,0,0,0);
    add(0,0,0,0,0,        1,1,1,0,0,          0,0,0,0,0,0, 0,0,0,1,0);
    add(0,1,0,16'h1000,5, 1,1,1,0,0,          0,1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,        1,1,1,1,0,          0,0,1,1,16'h1000,5, 0,0,0,0,0);
    add(0,0,0,0,0,        1,1,1,0,0,          0,0,0,0,0,0, 0,0,0,1,1);
    // Both requesters held valid: strict rd/wr alternation, never both ready.
    for (int i = 0; i < 4; i++) begin
      add(1,1,16'h2000,16'h3000,32'hAA, 1,1,1,0,0,   1,0,0,0,0,0, 0,0,0,0,0);
      add(1,1,16'h2000,16'h3000,32'hAA, 1,1,1,0,0,   0,0,1,0,16'h2000,0, 0,0,0,0,0);
      add(1,1,16'h2000,16'h3000,32'hAA, 1,1,1,0,32'h1100_0000+i, 0,0,0,0,0,0, 0,0,0,0,0);
      add(1,1,16'h2000,16'h3000,32'hAA, 1,1,1,0,0,   0,0,0,0,0,0, 1,32'h1100_0000+i,0,0,0);
      add(1,1,16'h2000,16'h3000,32'hAA, 1,1,1,0,0,   0,1,0,0,0,0, 0,0,0,0,0);
      add(1,1,16'h2000,16'h3000,32'hAA, 1,1,1,0,0,   0,0,1,1,16'h3000,32'hAA, 0,0,0,0,0);
      add(1,1,16'h2000,16'h3000,32'hAA, 1,1,1,0,0,   0,0,0,0,0,0, 0,0,0,1,0);
    end
    // Response backpressure holds the FSM and blocks the waiting writer.
    add(1,1,16'h2000,16'h3000,32'hBB, 1,1,1,0,0,     1,0,0,0,0,0, 0,0,0,0,0);
    add(1,1,16'h2000,16'h3000,32'hBB, 1,1,1,0,0,     0,0,1,0,16'h2000,0, 0,0,0,0,0);
    add(1,1,16'h2000,16'h3000,32'hBB, 1,1,1,1,32'h77, 0,0,0,0,0,0, 0,0,0,0,0);
    add(1,1,16'h2000,16'h3000,32'hBB, 0,1,1,0,0,     0,0,0,0,0,0, 1,32'h77,1,0,0);
    add(1,1,16'h2000,16'h3000,32'hBB, 0,1,1,0,0,     0,0,0,0,0,0, 1,32'h77,1,0,0);
    add(1,1,16'h2000,16'h3000,32'hBB, 1,1,1,0,0,     0,0,0,0,0,0, 1,32'h77,1,0,0);
    add(1,1,16'h2000,16'h3000,32'hBB, 1,1,1,0,0,     0,1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,                    1,0,1,0,0,     0,0,1,1,16'h3000,32'hBB, 0,0,0,0,0);
    add(0,0,0,0,0,                    1,0,1,0,0,     0,0,0,0,0,0, 0,0,0,1,0);
    add(0,0,0,0,0,                    1,1,1,0,0,     0,0,0,0,0,0, 0,0,0,1,0);

    // Reset values on both instances.
    @(negedge clk_axi);
    #1;
    chk("rst_rrdy", rd_req_ready_o, 0);    chk("rst_wrdy", wr_req_ready_o, 0);
    chk("rst_cv", csr_valid_o, 0);         chk("rst_rvld", rd_resp_valid_o, 0);
    chk("rst_wvld", wr_resp_valid_o, 0);   chk("rst_caddr", csr_addr_o, 0);
    chk("rst_cdo", csr_data_o, 0);         chk("rst_cw", csr_rd_or_wr_o, 0);
    chk("rst_rdat", rd_resp_data_o, 0);    chk("rst_rerr", rd_resp_err_o, 0);
    chk("rst_werr", wr_resp_err_o, 0);
    chk("rst3_rdy", {l_rd_req_ready, l_wr_req_ready, l_csr_valid, l_csr_rd_or_wr}, 0);
    chk("rst3_vld", {l_rd_resp_valid, l_wr_resp_valid, l_rd_resp_err, l_wr_resp_err}, 0);
    chk("rst3_caddr", l_csr_addr, 0);      chk("rst3_cdo", l_csr_data, 0);
    chk("rst3_rdat", l_rd_resp_data, 0);
    arst_axi = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_axi);
      rd_req_valid_i = vecs[i].rv;   wr_req_valid_i = vecs[i].wv;
      rd_addr_i = vecs[i].ra;        wr_addr_i = vecs[i].wa;        wr_data_i = vecs[i].wd;
      rd_resp_ready_i = vecs[i].rrr; wr_resp_ready_i = vecs[i].wrr;
      csr_ready_i = vecs[i].crdy;    csr_error_i = vecs[i].cerr;    csr_data_i = vecs[i].cdat;
      #1;
      chk($sformatf("v%0d_rrdy", i), rd_req_ready_o, vecs[i].e_rrdy);
      chk($sformatf("v%0d_wrdy", i), wr_req_ready_o, vecs[i].e_wrdy);
      chk($sformatf("v%0d_cv", i), csr_valid_o, vecs[i].e_cv);
      chk($sformatf("v%0d_rvld", i), rd_resp_valid_o, vecs[i].e_rvld);
      chk($sformatf("v%0d_wvld", i), wr_resp_valid_o, vecs[i].e_wvld);
      if (vecs[i].e_cv) begin
        chk($sformatf("v%0d_cw", i), csr_rd_or_wr_o, vecs[i].e_cw);
        chk($sformatf("v%0d_caddr", i), csr_addr_o, vecs[i].e_caddr);
        if (vecs[i].e_cw) chk($sformatf("v%0d_cdo", i), csr_data_o, vecs[i].e_cdo);
      end
      if (vecs[i].e_rvld) begin
        chk($sformatf("v%0d_rdat", i), rd_resp_data_o, vecs[i].e_rdat);
        chk($sformatf("v%0d_rerr", i), rd_resp_err_o, vecs[i].e_rerr);
      end
      if (vecs[i].e_wvld) chk($sformatf("v%0d_werr", i), wr_resp_err_o, vecs[i].e_werr);
    end

    // CSR stalls a write for 4 cycles while the requester's inputs change underneath.
    @(negedge clk_axi);
    idle_inputs();
    wr_req_valid_i = 1; wr_addr_i = 16'h1010; wr_data_i = 32'h55AA;
    #1 chk("stall_wrdy", wr_req_ready_o, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_axi);
      wr_req_valid_i = 0; wr_addr_i = 16'hFFFF; wr_data_i = 32'hDEAD_DEAD;
      csr_ready_i = 0; csr_error_i = 1;
      #1;
      chk($sformatf("stall%0d_cv", c), csr_valid_o, 1);
      chk($sformatf("stall%0d_caddr", c), csr_addr_o, 16'h1010);
      chk($sformatf("stall%0d_cdo", c), csr_data_o, 32'h55AA);
      chk($sformatf("stall%0d_wvld", c), wr_resp_valid_o, 0);
    end
    @(negedge clk_axi);
    csr_ready_i = 1; csr_error_i = 0;
    #1 chk("stall_rdy_cv", csr_valid_o, 1);
    @(negedge clk_axi);
    #1;
    chk("stall_wvld", wr_resp_valid_o, 1);
    chk("stall_werr", wr_resp_err_o, 0);

    // RD_LATENCY=3: data sampled 3 cycles after the CSR handshake, earlier values ignored.
    do_reset();
    rd_req_valid_i = 1; rd_addr_i = 16'h1234;
    #1;
    chk("lat_rrdy1", rd_req_ready_o, 1);
    chk("lat_rrdy3", l_rd_req_ready, 1);
    @(negedge clk_axi);
    rd_req_valid_i = 0;
    #1;
    chk("lat_cv1", csr_valid_o, 1);
    chk("lat_cv3", l_csr_valid, 1);
    @(negedge clk_axi);
    csr_data_i = 32'h0000_00A1;
    @(negedge clk_axi);
    csr_data_i = 32'hDEAD_BEEF;
    #1;
    chk("lat1_rvld", rd_resp_valid_o, 1);
    chk("lat1_rdat", rd_resp_data_o, 32'h0000_00A1);
    chk("lat3_early", l_rd_resp_valid, 0);
    @(negedge clk_axi);
    csr_data_i = 32'h0000_0C33;
    #1 chk("lat3_early2", l_rd_resp_valid, 0);
    @(negedge clk_axi);
    csr_data_i = 32'h0;
    #1;
    chk("lat3_rvld", l_rd_resp_valid, 1);
    chk("lat3_rdat", l_rd_resp_data, 32'h0000_0C33);

    // Reset pulse during RD_WAIT drops the read; tie afterwards goes to rd.
    do_reset();
    rd_req_valid_i = 1; rd_addr_i = 16'h2222;
    #1 chk("mid_rrdy", rd_req_ready_o, 1);
    @(negedge clk_axi);
    rd_req_valid_i = 0;
    @(negedge clk_axi);
    rd_req_valid_i = 1; wr_req_valid_i = 1;
    #3 arst_axi = 1;
    #1;
    chk("mid_rrdy0", rd_req_ready_o, 0);
    chk("mid_wrdy0", wr_req_ready_o, 0);
    chk("mid_cv0", csr_valid_o, 0);
    chk("mid_rvld0", rd_resp_valid_o, 0);
    chk("mid_wvld0", wr_resp_valid_o, 0);
    @(negedge clk_axi);
    arst_axi = 0; rd_req_valid_i = 0; wr_req_valid_i = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_axi);
      #1 chk($sformatf("mid_norvld%0d", c), rd_resp_valid_o, 0);
    end
    @(negedge clk_axi);
    rd_req_valid_i = 1; wr_req_valid_i = 1;
    #1;
    chk("mid_tie_rrdy", rd_req_ready_o, 1);
    chk("mid_tie_wrdy", wr_req_ready_o, 0);
    @(negedge clk_axi);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
